fetch_controller: RTL and testbench
===================================

Name: fetch_controller

Overview:
Sequences the program counter and the instruction-memory fetch port for the 16-bit single-issue core. It owns the PC state, issues one fetch request at a time, and tolerates multi-cycle memory latency. It applies decode stalls, branch/BR redirects and HLT, and presents a registered fetched instruction and its PC to the decode stage. It also keeps a saturating count of memory-wait cycles for performance debug.

Parameters:
RESET_PC  16'h0000  PC value loaded on reset
HLT_OPCODE  4'hF  opcode (instr[15:12]) that halts fetch

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
imem_req  out  1  fetch request to instruction memory
imem_addr  out  16  fetch address; always equals pc
imem_rdy  in  1  memory response valid this cycle (meaningful only while imem_req=1)
imem_data  in  16  fetched instruction, valid when imem_req & imem_rdy
stall  in  1  decode cannot accept a new instruction; hold if_* outputs
redirect_valid  in  1  branch taken / BR resolved; discard in-flight fetch
redirect_target  in  16  new PC on redirect
pc  out  16  current fetch PC
pc_plus_two  out  16  pc + 2, modulo 2^16 (combinational)
if_valid  out  1  if_instr/if_pc hold a valid instruction for decode
if_instr  out  16  registered fetched instruction
if_pc  out  16  PC of if_instr
halted  out  1  fetch has stopped on HLT
wait_cycles  out  16  count of cycles with imem_req=1 & imem_rdy=0; saturates at 16'hFFFF

Behaviour:
- All state updates occur on the rising edge of clk. rst is sampled synchronously and overrides every other input.
- Reset values: pc=RESET_PC, state=FETCH, if_valid=0, if_instr=16'h0000, if_pc=16'h0000, halted=0, wait_cycles=0.
- States: FETCH and HALTED.
- Outputs per state:
  - imem_req = (state==FETCH).
  - halted = (state==HALTED), registered.
  - imem_addr = pc at all times.
- FETCH, priority order, evaluated each cycle:
  1. redirect_valid: pc<=redirect_target; if_valid<=0; any imem_data this cycle is dropped; stall is ignored. Redirect squashes the if_* slot.
  2. stall: pc, if_* hold. A response arriving this cycle (imem_rdy=1) is discarded, and the same pc is re-requested next cycle. There is no response buffer.
  3. imem_rdy, with imem_data[15:12]!=HLT_OPCODE: if_instr<=imem_data; if_pc<=pc; if_valid<=1; pc<=pc+2.
  4. imem_rdy, with imem_data[15:12]==HLT_OPCODE: if_instr<=imem_data; if_pc<=pc; if_valid<=1; pc holds (not incremented); state<=HALTED.
  5. Otherwise (waiting on memory): if_valid<=0; pc holds.
- HALTED:
  - imem_req=0; pc holds.
  - redirect_valid: pc<=redirect_target; if_valid<=0; state<=FETCH. This covers an HLT fetched on a wrong path.
  - Otherwise, if stall=0: if_valid<=0 after the HLT has been presented for one accepted cycle. If stall=1, the if_* outputs hold.
  - The state is otherwise permanent until rst.
- Latency: with imem_rdy tied high and no stall, one instruction per cycle. An instruction fetched at pc in cycle N appears on if_* in cycle N+1.
- Arithmetic: pc+2 wraps (16'hFFFE -> 16'h0000). redirect_target is used as-is; no alignment check is performed.
- wait_cycles: increments in any cycle with state==FETCH, imem_rdy=0 and rst=0, including stall and redirect cycles. It holds at 16'hFFFF. Only rst clears it.
- Reset mid-fetch: the outstanding request is abandoned, and pc=RESET_PC in the cycle after rst.

Test Plan:
- Reset, then imem_rdy=1 with memory returning ADD (16'h0123) at every address, no stall -> pc sequence 0,2,4,6; if_pc trails by one cycle; if_valid=1 from cycle 2.
- imem_rdy low for 3 cycles at pc=0x0004, then high -> pc holds 0x0004; if_valid=0 for 3 cycles; wait_cycles=3; next if_pc=0x0004.
- stall=1 for 2 cycles while imem_rdy=1 at pc=0x0008 -> if_* hold their previous values; pc stays 0x0008; after the stall drops, the instruction at 0x0008 is delivered exactly once.
- redirect_valid=1, redirect_target=0x0100, together with imem_rdy=1 and stall=1 at pc=0x000A -> next cycle pc=0x0100 and if_valid=0; the 0x000A data is never presented.
- Fetch HLT (16'hF000) at 0x0010 -> if_instr=16'hF000, if_pc=0x0010; halted=1; imem_req=0; pc stays 0x0010. Then redirect to 0x0020 -> FETCH resumes at 0x0020 with halted=0.
- Load pc=0xFFFE via redirect -> the next sequential pc is 0x0000. Also force 65540 wait cycles -> wait_cycles=16'hFFFF.

Source files
------------

// File: rtl/fetch_controller.sv
// PC sequencer and instruction-fetch port for the 16-bit single-issue core.
// Holds one request in flight, applies stall/redirect/HLT, and counts memory waits.
module fetch_controller #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_rdy,
    input  logic [15:0] imem_data,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_target,
    output logic [15:0] pc,
    output logic [15:0] pc_plus_two,
    output logic        if_valid,
    output logic [15:0] if_instr,
    output logic [15:0] if_pc,
    output logic        halted,
    output logic [15:0] wait_cycles
);

    typedef enum logic {
        FETCH  = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] pc_next;
    logic        if_valid_next;
    logic [15:0] if_instr_next;
    logic [15:0] if_pc_next;
    logic [15:0] wait_next;
    logic        is_hlt;
    logic        mem_wait;

    assign pc_plus_two = pc + 16'd2;
    assign imem_addr   = pc;
    assign imem_req    = (state == FETCH);
    assign halted      = (state == HALTED);
    assign is_hlt      = (imem_data[15:12] == HLT_OPCODE);
    assign mem_wait    = (state == FETCH) && !imem_rdy;

    always_comb begin
        state_next    = state;
        pc_next       = pc;
        if_valid_next = if_valid;
        if_instr_next = if_instr;
        if_pc_next    = if_pc;
        case (state)
            FETCH: begin
                if (redirect_valid) begin
                    pc_next       = redirect_target;
                    if_valid_next = 1'b0;
                end else if (stall) begin
                    // Response (if any) is dropped; same pc is re-requested.
                    pc_next = pc;
                end else if (imem_rdy) begin
                    if_instr_next = imem_data;
                    if_pc_next    = pc;
                    if_valid_next = 1'b1;
                    if (is_hlt) begin
                        state_next = HALTED;
                    end else begin
                        pc_next = pc_plus_two;
                    end
                end else begin
                    if_valid_next = 1'b0;
                end
            end
            HALTED: begin
                if (redirect_valid) begin
                    pc_next       = redirect_target;
                    if_valid_next = 1'b0;
                    state_next    = FETCH;
                end else if (!stall) begin
                    if_valid_next = 1'b0;
                end
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    // Saturating debug counter of cycles spent waiting on memory.
    always_comb begin
        wait_next = wait_cycles;
        if (mem_wait && (wait_cycles != 16'hFFFF)) begin
            wait_next = wait_cycles + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            if_valid    <= 1'b0;
            if_instr    <= 16'h0000;
            if_pc       <= 16'h0000;
            wait_cycles <= 16'h0000;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            if_valid    <= if_valid_next;
            if_instr    <= if_instr_next;
            if_pc       <= if_pc_next;
            wait_cycles <= wait_next;
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed self-checking bench for fetch_controller.
// Inputs change #1 after posedge; outputs are checked there too.
module tb_fetch_controller;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rdy;
    logic [15:0] imem_data;
    logic        stall;
    logic        redirect_valid;
    logic [15:0] redirect_target;
    logic [15:0] pc;
    logic [15:0] pc_plus_two;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic        halted;
    logic [15:0] wait_cycles;

    int checks = 0;
    int errors = 0;

    fetch_controller #(
        .RESET_PC  (16'h0000),
        .HLT_OPCODE(4'hF)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdy       (imem_rdy),
        .imem_data      (imem_data),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .pc             (pc),
        .pc_plus_two    (pc_plus_two),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .halted         (halted),
        .wait_cycles    (wait_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        imem_rdy = 1'b0;
        imem_data = 16'h0000;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = 16'h0000;
        step();
        step();
        rst = 1'b0;

        chk("rst_pc", pc, 16'h0000);
        chk("rst_addr", imem_addr, 16'h0000);
        chk("rst_req", {15'd0, imem_req}, 16'd1);
        chk("rst_valid", {15'd0, if_valid}, 16'd0);
        chk("rst_instr", if_instr, 16'h0000);
        chk("rst_ifpc", if_pc, 16'h0000);
        chk("rst_halted", {15'd0, halted}, 16'd0);
        chk("rst_wait", wait_cycles, 16'd0);

        // Streaming at one instruction per cycle
        imem_rdy = 1'b1;
        imem_data = 16'h0123;
        step();
        chk("s1_pc", pc, 16'h0002);
        chk("s1_valid", {15'd0, if_valid}, 16'd1);
        chk("s1_ifpc", if_pc, 16'h0000);
        chk("s1_instr", if_instr, 16'h0123);
        step();
        chk("s2_pc", pc, 16'h0004);
        chk("s2_ifpc", if_pc, 16'h0002);

        // Three memory-wait cycles at 0x0004
        imem_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("w_pc", pc, 16'h0004);
            chk("w_valid", {15'd0, if_valid}, 16'd0);
        end
        chk("w_cnt", wait_cycles, 16'd3);
        imem_rdy = 1'b1;
        step();
        chk("w_done_pc", pc, 16'h0006);
        chk("w_done_ifpc", if_pc, 16'h0004);
        chk("w_done_valid", {15'd0, if_valid}, 16'd1);
        step();
        chk("p8_pc", pc, 16'h0008);
        chk("p8_ifpc", if_pc, 16'h0006);

        // Stall two cycles with data ready at 0x0008
        stall = 1'b1;
        imem_data = 16'h2008;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("st_pc", pc, 16'h0008);
            chk("st_ifpc", if_pc, 16'h0006);
            chk("st_instr", if_instr, 16'h0123);
            chk("st_valid", {15'd0, if_valid}, 16'd1);
        end
        chk("st_wait", wait_cycles, 16'd3);
        stall = 1'b0;
        step();
        chk("st_rel_pc", pc, 16'h000A);
        chk("st_rel_ifpc", if_pc, 16'h0008);
        chk("st_rel_instr", if_instr, 16'h2008);

        // Redirect beats stall and ready data
        redirect_valid = 1'b1;
        redirect_target = 16'h0100;
        stall = 1'b1;
        imem_data = 16'h300A;
        step();
        chk("rd_pc", pc, 16'h0100);
        chk("rd_valid", {15'd0, if_valid}, 16'd0);
        redirect_valid = 1'b0;
        stall = 1'b0;
        imem_data = 16'h0123;
        step();
        chk("rd_next_pc", pc, 16'h0102);
        chk("rd_next_ifpc", if_pc, 16'h0100);
        chk("rd_next_instr", if_instr, 16'h0123);

        // Redirect to 0x0010 during a memory wait
        redirect_valid = 1'b1;
        redirect_target = 16'h0010;
        imem_rdy = 1'b0;
        step();
        chk("rw_pc", pc, 16'h0010);
        chk("rw_wait", wait_cycles, 16'd4);
        redirect_valid = 1'b0;

        // HLT at 0x0010
        imem_rdy = 1'b1;
        imem_data = 16'hF000;
        step();
        chk("h_instr", if_instr, 16'hF000);
        chk("h_ifpc", if_pc, 16'h0010);
        chk("h_valid", {15'd0, if_valid}, 16'd1);
        chk("h_halted", {15'd0, halted}, 16'd1);
        chk("h_req", {15'd0, imem_req}, 16'd0);
        chk("h_pc", pc, 16'h0010);
        imem_rdy = 1'b0;
        stall = 1'b1;
        step();
        chk("h_st_valid", {15'd0, if_valid}, 16'd1);
        chk("h_st_wait", wait_cycles, 16'd4);
        stall = 1'b0;
        step();
        chk("h_acc_valid", {15'd0, if_valid}, 16'd0);
        chk("h_acc_halted", {15'd0, halted}, 16'd1);
        chk("h_acc_pc", pc, 16'h0010);

        // Leave HALTED by redirect
        redirect_valid = 1'b1;
        redirect_target = 16'h0020;
        step();
        chk("hr_pc", pc, 16'h0020);
        chk("hr_halted", {15'd0, halted}, 16'd0);
        chk("hr_req", {15'd0, imem_req}, 16'd1);
        redirect_valid = 1'b0;
        imem_rdy = 1'b1;
        imem_data = 16'h0123;
        step();
        chk("hr_next_pc", pc, 16'h0022);
        chk("hr_next_ifpc", if_pc, 16'h0020);

        // PC wrap
        redirect_valid = 1'b1;
        redirect_target = 16'hFFFE;
        imem_rdy = 1'b0;
        step();
        redirect_valid = 1'b0;
        chk("wr_pc", pc, 16'hFFFE);
        chk("wr_p2", pc_plus_two, 16'h0000);
        chk("wr_wait", wait_cycles, 16'd5);
        imem_rdy = 1'b1;
        step();
        chk("wr_next_pc", pc, 16'h0000);
        chk("wr_next_ifpc", if_pc, 16'hFFFE);

        // Wait counter saturation
        imem_rdy = 1'b0;
        for (int i = 0; i < 65540; i++) begin
            @(posedge clk);
        end
        #1;
        chk("sat_wait", wait_cycles, 16'hFFFF);
        step();
        chk("sat_hold", wait_cycles, 16'hFFFF);

        // Reset during an outstanding fetch
        imem_rdy = 1'b1;
        step();
        chk("mr_pre_pc", pc, 16'h0002);
        imem_rdy = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mr_pc", pc, 16'h0000);
        chk("mr_wait", wait_cycles, 16'd0);
        chk("mr_valid", {15'd0, if_valid}, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
